// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the memory controller.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_fault;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_fault;

    logic        mem_ce;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_memwrite;
    logic [31:0] mem_dataout;
    logic        mem_busy;
    logic        mem_valid;
    logic        mem_fault;
    logic        mem_timeout;

    modport slave (
        input  if_req, if_addr,
        output if_rvalid, if_rdata, if_fault,
        input  d_req, d_we, d_funct3, d_addr, d_wdata,
        output d_rvalid, d_rdata, d_fault,
        output mem_ce, mem_funct3, mem_addr, mem_datain, mem_memwrite, mem_timeout,
        input  mem_dataout, mem_busy, mem_valid, mem_fault
    );

    modport master (
        output if_req, if_addr,
        input  if_rvalid, if_rdata, if_fault,
        output d_req, d_we, d_funct3, d_addr, d_wdata,
        input  d_rvalid, d_rdata, d_fault,
        input  mem_ce, mem_funct3, mem_addr, mem_datain, mem_memwrite, mem_timeout,
        output mem_dataout, mem_busy, mem_valid, mem_fault
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one memory controller between fetch and data ports,
// with a ce release cycle between transactions and a watchdog that aborts hung accesses.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] FETCH_F3 = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_latch;
    logic            w_done;
    logic            w_abort;
    logic            w_release;
    logic            w_pick_d;

    logic            r_last_d;   // 1 = data port was granted last
    logic            r_gnt_d;
    logic [WD_W-1:0] r_wdog;

    logic            r_ce;
    logic [2:0]      r_f3;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_we;

    logic            r_if_rvalid;
    logic [31:0]     r_if_rdata;
    logic            r_if_fault;
    logic            r_d_rvalid;
    logic [31:0]     r_d_rdata;
    logic            r_d_fault;
    logic            r_timeout;

    logic [31:0]     w_rdata;

    // On a tie the port that did not win last time gets the controller.
    assign w_pick_d = bus.d_req & (~bus.if_req | ~r_last_d);
    assign w_rdata  = (bus.mem_valid & ~r_we) ? bus.mem_dataout : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_done    = 1'b0;
        w_abort   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.if_req | bus.d_req) begin
                    w_latch = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (!bus.mem_busy) begin
                    w_done = 1'b1;
                    w_next = S_RELEASE;
                end else if (r_wdog == WD_LAST) begin
                    w_abort = 1'b1;
                    w_next  = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_release = 1'b1;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_d    <= 1'b0;
            r_gnt_d     <= 1'b0;
            r_wdog      <= '0;
            r_ce        <= 1'b1;
            r_f3        <= 3'b000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_we        <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_if_fault  <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_rdata   <= 32'h0;
            r_d_fault   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_fault  <= 1'b0;
            r_d_fault   <= 1'b0;
            r_timeout   <= 1'b0;

            if (w_latch) begin
                r_ce    <= 1'b0;
                r_gnt_d <= w_pick_d;
                if (w_pick_d) begin
                    r_f3    <= bus.d_funct3;
                    r_addr  <= bus.d_addr;
                    r_wdata <= bus.d_wdata;
                    r_we    <= bus.d_we;
                end else begin
                    r_f3    <= FETCH_F3;
                    r_addr  <= bus.if_addr;
                    r_wdata <= 32'h0;
                    r_we    <= 1'b0;
                end
            end else if (w_done | w_abort) begin
                r_ce <= 1'b1;
            end

            if (r_state == S_ISSUE)     r_wdog <= '0;
            else if (r_state == S_WAIT) r_wdog <= r_wdog + WD_W'(1);

            // Response registers load on the edge into RELEASE so the pulse lines up with ce high.
            if (w_done | w_abort) begin
                if (r_gnt_d) begin
                    r_d_rvalid <= 1'b1;
                    r_d_rdata  <= w_abort ? 32'h0 : w_rdata;
                    r_d_fault  <= w_abort | bus.mem_fault;
                end else begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= w_abort ? 32'h0 : w_rdata;
                    r_if_fault  <= w_abort | bus.mem_fault;
                end
                r_timeout <= w_abort;
            end

            if (w_release) r_last_d <= r_gnt_d;
        end
    end

    assign bus.mem_ce       = r_ce;
    assign bus.mem_funct3   = r_f3;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_datain   = r_wdata;
    assign bus.mem_memwrite = r_we;
    assign bus.mem_timeout  = r_timeout;
    assign bus.if_rvalid    = r_if_rvalid;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.if_fault     = r_if_fault;
    assign bus.d_rvalid     = r_d_rvalid;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_fault      = r_d_fault;
endmodule
